// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader, CPU top and memory.
package imem_loader_pkg;

    localparam int unsigned DEPTH_DEFAULT = 64;
    localparam logic [7:0]  SYNC_DEFAULT  = 8'hA5;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned WORD_W        = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and memory-write/status bundle of the loader.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              we;
    logic [WORD_W-1:0] waddr;
    logic [WORD_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, we, waddr, wdata, busy, done, err
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, we, waddr, wdata, busy, done, err
    );

endinterface

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word shifter with byte counter and XOR checksum.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic [BYTE_W-1:0] csum_o,
    output logic              last_c_o
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [BYTE_W-1:0] csum_q, csum_d;
    logic [1:0]        cnt_q, cnt_d;

    // New bytes enter at the top so the first byte ends up in [7:0].
    always_comb begin
        word_d = word_q;
        csum_d = csum_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            word_d = '0;
            csum_d = '0;
            cnt_d  = '0;
        end else if (shift_i) begin
            word_d = {byte_i, word_q[WORD_W-1:BYTE_W]};
            csum_d = csum_q ^ byte_i;
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            csum_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            csum_q <= csum_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o   = word_q;
    assign csum_o   = csum_q;
    assign last_c_o = (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Frame-driven instruction-memory loader: SYNC, word count, data words, XOR checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter logic [7:0]  SYNC  = SYNC_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH + 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [IDX_W-1:0]  len_q, len_d;
    logic [WORD_W-1:0] waddr_q, waddr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic              rx_ready_q, rx_ready_d;

    logic              accept;
    logic              pk_clear;
    logic              pk_shift;
    logic [WORD_W-1:0] pk_word;
    logic [BYTE_W-1:0] pk_csum;
    logic              pk_last;

    assign accept = bus.rx_valid && rx_ready_q;

    imem_word_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (pk_clear),
        .shift_i  (pk_shift),
        .byte_i   (bus.rx_data),
        .word_o   (pk_word),
        .csum_o   (pk_csum),
        .last_c_o (pk_last)
    );

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        len_d    = len_q;
        waddr_d  = waddr_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        pk_clear = 1'b0;
        pk_shift = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (accept && bus.rx_data == SYNC) begin
                    state_d  = S_LEN;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    pk_clear = 1'b1;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (bus.rx_data == 8'd0 || 32'(bus.rx_data) > 32'(DEPTH)) begin
                        state_d = S_ERR;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        len_d   = IDX_W'(bus.rx_data);
                        index_d = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    pk_shift = 1'b1;
                    if (pk_last) begin
                        state_d = S_WRITE;
                        waddr_d = 32'({index_q, 2'b00});
                    end
                end
            end
            S_WRITE: begin
                index_d = index_q + IDX_W'(1);
                state_d = (index_q + IDX_W'(1) == len_q) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (accept) begin
                    busy_d = 1'b0;
                    if (bus.rx_data == pk_csum) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Byte intake pauses only for the single write cycle.
        we_d       = (state_d == S_WRITE);
        rx_ready_d = (state_d != S_WRITE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            index_q    <= '0;
            len_q      <= '0;
            waddr_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            len_q      <= len_d;
            waddr_q    <= waddr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            we_q       <= we_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.we       = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = pk_word;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, giving the instruction-memory depth in 32-bit words.
REQ-002 The block SHALL have parameter SYNC, default 8'hA5, giving the frame start byte.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port rx_data, input, 8 bits: incoming byte, e.g. from a UART receiver.
REQ-006 Port rx_valid, input, 1 bit: rx_data holds a byte.
REQ-007 Port rx_ready, output, 1 bit: the loader can accept a byte.
REQ-008 Port we, output, 1 bit: instruction-memory write strobe, one cycle wide.
REQ-009 Port waddr, output, 32 bits: byte address of the write, always word-aligned (waddr[1:0]=0); the memory indexes with waddr[31:2].
REQ-010 Port wdata, output, 32 bits: instruction word to write.
REQ-011 Port busy, output, 1 bit: a load is in progress; the CPU is held in reset while it is high.
REQ-012 Port done, output, 1 bit: the last load finished with a good checksum.
REQ-013 Port err, output, 1 bit: the last load failed.

Function
REQ-014 A byte SHALL be accepted only in a cycle where rx_valid=1 and rx_ready=1.
REQ-015 rx_ready SHALL be 1 in every state except during reset and in the cycle we=1.
REQ-016 The FSM SHALL have the states IDLE, LEN, DATA, WRITE, CSUM, DONE and ERR.
REQ-017 IDLE: an accepted byte equal to SYNC SHALL move to LEN and set busy=1; any other byte SHALL be dropped.
REQ-018 LEN: the accepted byte N is a word count; N=0 or N>DEPTH SHALL move to ERR; otherwise the word index SHALL clear to 0 and the FSM SHALL move to DATA.
REQ-019 DATA: bytes SHALL be packed little-endian (the first byte goes to wdata[7:0]); each accepted byte SHALL be XORed into an 8-bit running checksum that was cleared on SYNC.
REQ-020 When the 4th byte of a word is accepted, the FSM SHALL enter WRITE; in the next cycle we=1, wdata=the packed word and waddr=4*index.
REQ-021 WRITE SHALL last exactly one cycle, then increment the index; if index+1 = N the FSM SHALL go to CSUM, otherwise back to DATA.
REQ-022 CSUM: an accepted byte equal to the running checksum SHALL move to DONE, otherwise to ERR.
REQ-023 Words already written before an ERR SHALL NOT be rolled back.
REQ-024 On entering DONE or ERR, busy SHALL drop to 0.
REQ-025 done and err SHALL be levels that hold until the next accepted SYNC byte, which clears both and restarts at LEN.
REQ-026 A non-SYNC byte received in DONE or ERR SHALL be dropped.
REQ-027 A SYNC-valued byte received in LEN, DATA or CSUM SHALL be treated as data (no resynchronisation mid-frame).
REQ-028 The index counter SHALL be wide enough for DEPTH with no wrap; N=DEPTH SHALL write the last address 4*(DEPTH-1).
REQ-029 Outside WRITE, we SHALL be 0; wdata and waddr are don't-care.

Reset
REQ-030 Asserting reset SHALL immediately and asynchronously put the FSM in IDLE and force we=0, busy=0, done=0, err=0, rx_ready=0, waddr=0, wdata=0, index=0 and checksum=0.
REQ-031 Reset in the middle of a frame SHALL abandon the frame; after release the block SHALL require a new SYNC.
REQ-032 rx_ready SHALL rise in the first clock cycle after reset deasserts.

Structure
REQ-033 A shared package SHALL hold the state enum, the SYNC default and the DEPTH default, so the CPU top and the memory share them.
REQ-034 One sub-module, imem_word_packer, SHALL do the byte-to-word shift, the 2-bit byte counter and the XOR accumulate; all other logic stays in imem_loader.

Verification
REQ-035 Send A5 03 b7 07 00 40 13 07 f0 0f 23 a0 e7 00 7F -> three we pulses: (0x00, 400007b7), (0x04, 0ff00713), (0x08, 00e7a023); then done=1, busy=0, err=0.
REQ-036 Send the same frame with checksum 0x7E -> three writes happen, then err=1, done=0.
REQ-037 Send A5 00, and separately A5 41 with DEPTH=64 -> err=1 and no we pulse in either case.
REQ-038 Send 11 22 A5 01 A5 00 00 00 A5 -> leading bytes dropped; one write (0x00, 000000A5); checksum A5 matches, so done=1.
REQ-039 Assert reset after the 6th byte of the REQ-035 frame, then resend the whole frame -> only the resent frame produces writes, and it ends with done=1.
REQ-040 Drive the REQ-035 frame with random rx_valid gaps of 0-5 cycles -> identical writes and result; rx_ready=0 exactly in each WRITE cycle.
